jesd_tx_ctrl: RTL



---
 rtl/jesd_tx_pkg.sv | 20 ++
 rtl/jesd_sync_monitor.sv | 61 ++++++
 rtl/jesd_tx_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/jesd_tx_pkg.sv
// rtl/jesd_tx_pkg.sv - shared types and constants for the JESD204B TX link controller
package jesd_tx_pkg;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_WAIT_PHY = 3'd1,
        ST_CGS      = 3'd2,
        ST_ILAS     = 3'd3,
        ST_DATA     = 3'd4
    } state_e;

    // Control characters inserted by the per-lane framer
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    localparam logic [3:0] ILAS_CFG_MF_IDX = 4'd1;

endpackage

// File: rtl/jesd_sync_monitor.sv
// rtl/jesd_sync_monitor.sv - SYNC~ reduction, debounce, resync detection and error-report counting
module jesd_sync_monitor
    import jesd_tx_pkg::*;
#(
    parameter int LINKS         = 1,
    parameter int SYNC_DEBOUNCE = 8,
    parameter int RESYNC_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [LINKS-1:0] i_sync_n,
    input  logic [LINKS-1:0] i_link_disable,
    input  logic             i_clear,
    input  logic             i_mon_en,
    output logic             o_sync_stable,
    output logic             o_resync_req,
    output logic [7:0]       o_err_cnt
);

    localparam logic [7:0] DEB_MAX     = 8'(SYNC_DEBOUNCE);
    localparam logic [7:0] RESYNC_LAST = 8'(RESYNC_CYCLES - 1);

    logic       w_sync_ok;
    logic       w_resync_req;
    logic [7:0] r_deb_cnt;
    logic [7:0] r_resync_cnt;
    logic [7:0] r_err_cnt;

    assign w_sync_ok     = &(i_sync_n | i_link_disable);
    assign o_sync_stable = (r_deb_cnt == DEB_MAX);
    // Fires in the cycle the low run reaches RESYNC_CYCLES, so the FSM leaves on that edge
    assign w_resync_req  = i_mon_en && !w_sync_ok && (r_resync_cnt == RESYNC_LAST);
    assign o_resync_req  = w_resync_req;
    assign o_err_cnt     = r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb_cnt    <= '0;
            r_resync_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (i_clear || !w_sync_ok) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != DEB_MAX) begin
                r_deb_cnt <= r_deb_cnt + 8'd1;
            end

            if (!i_mon_en || w_resync_req) begin
                r_resync_cnt <= '0;
            end else if (!w_sync_ok) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end else begin
                if ((r_resync_cnt != 8'd0) && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_resync_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/jesd_tx_ctrl.sv
// rtl/jesd_tx_ctrl.sv - JESD204B TX link-control FSM sequencing GT reset, CGS, ILAS and data
module jesd_tx_ctrl
    import jesd_tx_pkg::*;
#(
    parameter int L                = 1,
    parameter int LINKS            = 1,
    parameter int RESET_CYCLES     = 4,
    parameter int SYNC_DEBOUNCE    = 8,
    parameter int RESYNC_CYCLES    = 4,
    parameter int ILAS_MULTIFRAMES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [L-1:0]     lane_disable_i,
    input  logic [LINKS-1:0] link_disable_i,
    input  logic             phy_ready_i,
    input  logic [LINKS-1:0] sync_ni,
    input  logic             lmfc_clk_i,
    output logic             tx_reset_gt_o,
    output logic [L-1:0]     cgs_en_o,
    output logic [L-1:0]     ilas_en_o,
    output logic [3:0]       ilas_mf_idx_o,
    output logic             ilas_cfg_o,
    output logic [L-1:0]     data_en_o,
    output logic [7:0]       sync_err_cnt_o,
    output logic [2:0]       state_o
);

    localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);
    localparam logic [3:0] MF_LAST  = 4'(ILAS_MULTIFRAMES - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_rst_cnt;
    logic [3:0] w_rst_cnt_nxt;
    logic [3:0] r_mf_idx;
    logic [3:0] w_mf_nxt;
    logic       w_sync_stable;
    logic       w_resync_req;
    logic       r_tx_reset;
    logic       r_ilas_cfg;
    logic [L-1:0] r_cgs_en;
    logic [L-1:0] r_ilas_en;
    logic [L-1:0] r_data_en;

    jesd_sync_monitor #(
        .LINKS         (LINKS),
        .SYNC_DEBOUNCE (SYNC_DEBOUNCE),
        .RESYNC_CYCLES (RESYNC_CYCLES)
    ) u_sync_mon (
        .i_clk          (clk_i),
        .i_rst          (rst_i),
        .i_sync_n       (sync_ni),
        .i_link_disable (link_disable_i),
        .i_clear        (r_state != ST_CGS),
        .i_mon_en       ((r_state == ST_ILAS) || (r_state == ST_DATA)),
        .o_sync_stable  (w_sync_stable),
        .o_resync_req   (w_resync_req),
        .o_err_cnt      (sync_err_cnt_o)
    );

    // PHY loss outranks resync, which outranks the LMFC-driven advance
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = 4'd0;
        w_mf_nxt      = 4'd0;
        case (r_state)
            ST_RESET: begin
                if (r_rst_cnt == RST_LAST) w_state_nxt = ST_WAIT_PHY;
                else                       w_rst_cnt_nxt = r_rst_cnt + 4'd1;
            end
            ST_WAIT_PHY: begin
                if (phy_ready_i) w_state_nxt = ST_CGS;
            end
            ST_CGS: begin
                if (!phy_ready_i)                     w_state_nxt = ST_RESET;
                else if (w_sync_stable && lmfc_clk_i) w_state_nxt = ST_ILAS;
            end
            ST_ILAS: begin
                if (!phy_ready_i) begin
                    w_state_nxt = ST_RESET;
                end else if (w_resync_req) begin
                    w_state_nxt = ST_CGS;
                end else if (lmfc_clk_i && (r_mf_idx == MF_LAST)) begin
                    w_state_nxt = ST_DATA;
                end else if (lmfc_clk_i) begin
                    w_mf_nxt = r_mf_idx + 4'd1;
                end else begin
                    w_mf_nxt = r_mf_idx;
                end
            end
            ST_DATA: begin
                if (!phy_ready_i)      w_state_nxt = ST_RESET;
                else if (w_resync_req) w_state_nxt = ST_CGS;
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RESET;
            r_rst_cnt  <= 4'd0;
            r_mf_idx   <= 4'd0;
            r_tx_reset <= 1'b1;
            r_ilas_cfg <= 1'b0;
            r_cgs_en   <= '0;
            r_ilas_en  <= '0;
            r_data_en  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_cnt  <= w_rst_cnt_nxt;
            r_mf_idx   <= w_mf_nxt;
            r_tx_reset <= (w_state_nxt == ST_RESET);
            r_ilas_cfg <= (w_state_nxt == ST_ILAS) && (w_mf_nxt == ILAS_CFG_MF_IDX);
            r_cgs_en   <= (w_state_nxt == ST_CGS)  ? ~lane_disable_i : '0;
            r_ilas_en  <= (w_state_nxt == ST_ILAS) ? ~lane_disable_i : '0;
            r_data_en  <= (w_state_nxt == ST_DATA) ? ~lane_disable_i : '0;
        end
    end

    assign tx_reset_gt_o = r_tx_reset;
    assign cgs_en_o      = r_cgs_en;
    assign ilas_en_o     = r_ilas_en;
    assign data_en_o     = r_data_en;
    assign ilas_mf_idx_o = r_mf_idx;
    assign ilas_cfg_o    = r_ilas_cfg;
    assign state_o       = r_state;

endmodule
